// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared types and default parameters for the multiport register file
package regfile_pkg;

    localparam int DEF_DATA_W   = 32;
    localparam int DEF_ADDR_W   = 5;
    localparam int DEF_NREAD    = 2;
    localparam int DEF_ZERO_REG = 1;
    localparam int DEF_BYPASS   = 1;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_e;

endpackage

// File: rtl/regfile_multiport_if.sv
// rtl/regfile_multiport_if.sv - read/write/clear bus of the multiport register file
interface regfile_multiport_if
    import regfile_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int NREAD  = DEF_NREAD
);
    logic [NREAD*ADDR_W-1:0] ra;
    logic [NREAD*DATA_W-1:0] rd;
    logic [ADDR_W-1:0]       wa;
    logic [DATA_W-1:0]       wd;
    logic                    we;
    logic [DATA_W/8-1:0]     wbe;
    logic                    clr_req;
    logic                    clr_busy;

    modport master (
        output ra, wa, wd, we, wbe, clr_req,
        input  rd, clr_busy
    );

    modport slave (
        input  ra, wa, wd, we, wbe, clr_req,
        output rd, clr_busy
    );
endinterface

// File: rtl/regfile_clear_seq.sv
// rtl/regfile_clear_seq.sv - bulk clear sequencer: walks every entry once per clr_req
module regfile_clear_seq
    import regfile_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_req,
    output logic              clr_busy,
    output logic              clr_en,
    output logic [ADDR_W-1:0] clr_idx
);
    localparam logic [ADDR_W-1:0] LAST_IDX = '1;

    clr_state_e        r_state;
    logic [ADDR_W-1:0] r_idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_idx   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (clr_req) begin
                        r_state <= CLEAR;
                        r_idx   <= '0;
                    end
                end
                CLEAR: begin
                    // Index parks on the last entry instead of wrapping
                    if (r_idx == LAST_IDX) begin
                        r_state <= IDLE;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
            endcase
        end
    end

    assign clr_busy = (r_state == CLEAR);
    assign clr_en   = (r_state == CLEAR);
    assign clr_idx  = r_idx;

endmodule

// File: rtl/regfile_multiport.sv
// rtl/regfile_multiport.sv - register file with N combinational read ports, byte-enabled write,
// optional write-to-read bypass, hardwired zero entry and a bulk clear sweep
module regfile_multiport
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int NREAD    = DEF_NREAD,
    parameter int ZERO_REG = DEF_ZERO_REG,
    parameter int BYPASS   = DEF_BYPASS
) (
    input  logic              clk,
    input  logic              rst,
    regfile_multiport_if.slave bus
);
    localparam int DEPTH  = 1 << ADDR_W;
    localparam int NBYTES = DATA_W / 8;

    logic [DATA_W-1:0]       r_mem [DEPTH];
    logic                    w_clr_busy;
    logic                    w_clr_en;
    logic [ADDR_W-1:0]       w_clr_idx;
    logic                    w_wr_en;
    logic [DATA_W-1:0]       w_be_mask;
    logic [DATA_W-1:0]       w_port [NREAD];
    logic [NREAD*DATA_W-1:0] w_rd;

    regfile_clear_seq #(
        .ADDR_W (ADDR_W)
    ) u_clear_seq (
        .clk      (clk),
        .rst      (rst),
        .clr_req  (bus.clr_req),
        .clr_busy (w_clr_busy),
        .clr_en   (w_clr_en),
        .clr_idx  (w_clr_idx)
    );

    always_comb begin
        w_be_mask = '0;
        for (int b = 0; b < NBYTES; b++) begin
            w_be_mask[8*b +: 8] = {8{bus.wbe[b]}};
        end
    end

    // Entry 0 writes are dropped here so the bypass path never sees them either
    assign w_wr_en = bus.we && !w_clr_busy && !((ZERO_REG != 0) && (bus.wa == '0));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int j = 0; j < DEPTH; j++) begin
                r_mem[j] <= '0;
            end
        end else if (w_clr_en) begin
            r_mem[w_clr_idx] <= '0;
        end else if (w_wr_en) begin
            r_mem[bus.wa] <= (bus.wd & w_be_mask) | (r_mem[bus.wa] & ~w_be_mask);
        end
    end

    for (genvar gi = 0; gi < NREAD; gi++) begin : g_rd
        logic [ADDR_W-1:0] w_ra;
        logic [DATA_W-1:0] w_stored;
        logic              w_hit;

        assign w_ra     = bus.ra[gi*ADDR_W +: ADDR_W];
        assign w_stored = ((ZERO_REG != 0) && (w_ra == '0)) ? '0 : r_mem[w_ra];
        assign w_hit    = (BYPASS != 0) && w_wr_en && (bus.wa == w_ra);
        assign w_port[gi] = w_hit ? ((bus.wd & w_be_mask) | (w_stored & ~w_be_mask))
                                  : w_stored;
    end

    always_comb begin
        w_rd = '0;
        for (int i = 0; i < NREAD; i++) begin
            w_rd[i*DATA_W +: DATA_W] = w_port[i];
        end
    end

    assign bus.rd       = w_rd;
    assign bus.clr_busy = w_clr_busy;

endmodule
